// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for the synchronous program ROM read port: one access in flight, response held until consumed.
// Optional feature: define ROM_ARB_RR_EN for round-robin tie-breaking (default: port 1 wins ties).
module rom_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner;
    logic                r_err;
    logic                r_last_grant;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [DATA_W-1:0]   r_data;

    logic                w_tie_win;
    logic                w_win;
    logic                w_accept;
    logic                w_rsp_hs;
    logic [ADDR_W-1:0]   w_sel_addr;

`ifdef ROM_ARB_RR_EN
    assign w_tie_win = ~r_last_grant;
`else
    // last_grant is tracked in both builds; fixed priority simply ignores it
    assign w_tie_win = r_last_grant | 1'b1;
`endif

    assign w_win      = (req0_valid && req1_valid) ? w_tie_win : req1_valid;
    // Gating with rst_n keeps every ready low while reset is held, not just after the edge
    assign w_accept   = (r_state == IDLE) && (req0_valid || req1_valid) && rst_n;
    assign w_sel_addr = w_win ? req1_addr : req0_addr;
    assign w_rsp_hs   = r_owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = WAIT;
            WAIT:    w_next = RESP;
            RESP:    if (w_rsp_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = w_accept && !w_win;
        req1_ready = w_accept && w_win;
        rsp0_valid = (r_state == RESP) && !r_owner;
        rsp1_valid = (r_state == RESP) && r_owner;
        rsp0_err   = rsp0_valid && r_err;
        rsp1_err   = rsp1_valid && r_err;
        rsp0_data  = r_data;
        rsp1_data  = r_data;
        rom_addr   = w_accept ? w_sel_addr : r_last_addr;
        busy       = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= 1'b0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b0;
            r_last_addr  <= '0;
            r_data       <= '0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_win;
                r_err        <= |w_sel_addr[1:0];
                r_last_grant <= w_win;
                r_last_addr  <= w_sel_addr;
            end
            if (r_state == WAIT) begin
                r_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed vector table, multi-cycle sequences and a randomized run against a cycle model.
// Honours ROM_ARB_RR_EN to select the expected tie-break rule.
module tb_rom_port_arbiter;

`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [13:0] req0_addr, req1_addr, rom_addr;
    logic [31:0] rsp0_data, rsp1_data, rom_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int last_grant_m = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    // ROM contents: byte[a] = a[7:0], big-endian word, so wrap past the top is just 8-bit overflow
    function automatic logic [31:0] romword(input logic [13:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    always @(posedge clk) rom_data <= romword(rom_addr);

    // Requester-side protocol: a pending request keeps valid and addr until accepted
    logic        pv0 = 1'b0, pv1 = 1'b0;
    logic [13:0] pa0, pa1;
    always @(posedge clk) begin
        if (rst_n) begin
            if (pv0) assert (req0_valid && req0_addr == pa0) else $error("FAIL protocol port0 request dropped");
            if (pv1) assert (req1_valid && req1_addr == pa1) else $error("FAIL protocol port1 request dropped");
        end
        pv0 <= rst_n && req0_valid && !req0_ready;
        pv1 <= rst_n && req1_valid && !req1_ready;
        pa0 <= req0_addr;
        pa1 <= req1_addr;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with requests already driven; returns at negedge+1 after the response handshake
    task automatic do_txn(input string nm, input int exp_port, input logic [13:0] exp_addr,
                          input logic [31:0] exp_d, input logic exp_e, input bit keep);
        int k;
        int got;
        k = 0;
        #1;
        while (!(req0_ready || req1_ready) && k < 10) begin
            @(negedge clk); #1; k++;
        end
        if (!(req0_ready || req1_ready)) begin
            chk({nm, " accept_timeout"}, 32'd0, 32'd1);
            return;
        end
        got = req1_ready ? 1 : 0;
        chk({nm, " grant"}, got, exp_port);
        chk({nm, " single_ready"}, req0_ready & req1_ready, 1'b0);
        chk({nm, " rom_addr"}, rom_addr, exp_addr);
        last_grant_m = got;
        @(negedge clk);
        if (!keep) begin
            if (got == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        end
        #1;
        chk({nm, " wait_rsp_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
        chk({nm, " wait_ready"}, {req0_ready, req1_ready}, 2'b00);
        chk({nm, " wait_busy"}, busy, 1'b1);
        @(negedge clk); #1;
        chk({nm, " rsp_valid"}, {rsp1_valid, rsp0_valid}, (got == 1) ? 2'b10 : 2'b01);
        chk({nm, " rsp_data"}, (got == 1) ? rsp1_data : rsp0_data, exp_d);
        chk({nm, " rsp_err"}, (got == 1) ? rsp1_err : rsp0_err, exp_e);
        if (got == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        chk({nm, " post_rsp_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
        chk({nm, " post_busy"}, busy, 1'b0);
    endtask

    typedef struct {
        logic        v0;
        logic [13:0] a0;
        logic        v1;
        logic [13:0] a1;
        int          first_fx;
        int          first_rr;
        logic [31:0] d0;
        logic        e0;
        logic [31:0] d1;
        logic        e1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int drop;
        int w;
        bit ev;
        bit pend[2];
        logic [13:0] paddr[2];
        bit out_active;
        int owner, acc_n, lastg;
        logic [31:0] exp_d;
        logic exp_e;

        vecs[0] = '{1'b1, 14'h0004, 1'b0, 14'h0000, 0, 0, 32'h04050607, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b1, 14'h0010, 1'b1, 14'h0020, 1, 1, 32'h10111213, 1'b0, 32'h20212223, 1'b0};
        vecs[2] = '{1'b0, 14'h0000, 1'b1, 14'h0006, 1, 1, 32'h0, 1'b0, 32'h06070809, 1'b1};
        vecs[3] = '{1'b1, 14'h0010, 1'b1, 14'h0020, 1, 0, 32'h10111213, 1'b0, 32'h20212223, 1'b0};
        vecs[4] = '{1'b0, 14'h0000, 1'b1, 14'h3FFE, 1, 1, 32'h0, 1'b0, 32'hFEFF0001, 1'b1};
        vecs[5] = '{1'b1, 14'h0001, 1'b0, 14'h0000, 0, 0, 32'h01020304, 1'b1, 32'h0, 1'b0};
        vecs[6] = '{1'b1, 14'h0003, 1'b1, 14'h3FFD, 1, 1, 32'h03040506, 1'b1, 32'hFDFEFF00, 1'b1};

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset ready", {req0_ready, req1_ready}, 2'b00);
        chk("reset rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("reset rom_addr", rom_addr, 14'h0000);
        chk("reset rsp_data", rsp0_data, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Vector table: each row serves every valid port, tie winner first
        foreach (vecs[i]) begin
            @(negedge clk);
            req0_valid = vecs[i].v0; req0_addr = vecs[i].a0;
            req1_valid = vecs[i].v1; req1_addr = vecs[i].a1;
            first = RR ? vecs[i].first_rr : vecs[i].first_fx;
            if (first == 1) begin
                do_txn($sformatf("vec%0d p1", i), 1, vecs[i].a1, vecs[i].d1, vecs[i].e1, 1'b0);
                if (vecs[i].v0) do_txn($sformatf("vec%0d p0", i), 0, vecs[i].a0, vecs[i].d0, vecs[i].e0, 1'b0);
            end else begin
                do_txn($sformatf("vec%0d p0", i), 0, vecs[i].a0, vecs[i].d0, vecs[i].e0, 1'b0);
                if (vecs[i].v1) do_txn($sformatf("vec%0d p1", i), 1, vecs[i].a1, vecs[i].d1, vecs[i].e1, 1'b0);
            end
        end

        // Back-pressure on port 1 while port 0 waits
        @(negedge clk);
        req1_valid = 1'b1; req1_addr = 14'h0024;
        #1;
        chk("bp accept1", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 14'h0028;
        #1;
        chk("bp wait ready0", req0_ready, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("bp rsp1_valid", rsp1_valid, 1'b1);
            chk("bp rsp1_data", rsp1_data, 32'h24252627);
            chk("bp ready0", req0_ready, 1'b0);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        do_txn("bp resume p0", 0, 14'h0028, 32'h28292A2B, 1'b0, 1'b0);

        // Reset in the middle of an access
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 14'h0008;
        #1;
        chk("rst accept0", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("rst pre busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("rst rom_addr", rom_addr, 14'h0000);
        chk("rst data", {rsp0_data, rsp1_data}, 64'h0);
        chk("rst err", {rsp0_err, rsp1_err}, 2'b00);
        last_grant_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rst no_rsp", {rsp0_valid, rsp1_valid, busy}, 3'b000);
        end
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 14'h000C;
        do_txn("rst after p0", 0, 14'h000C, 32'h0C0D0E0F, 1'b0, 1'b0);

        // Continuous contention for 10 grants
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 14'h0100;
        req1_valid = 1'b1; req1_addr = 14'h0204;
        first = RR ? 1 - last_grant_m : 1;
        for (int i = 0; i < 10; i++) begin
            if (first == 1) do_txn($sformatf("cont%0d", i), 1, 14'h0204, 32'h04050607, 1'b0, i < 9);
            else            do_txn($sformatf("cont%0d", i), 0, 14'h0100, 32'h00010203, 1'b0, i < 9);
            if (RR) first = 1 - first;
        end
        if (last_grant_m == 1) do_txn("cont tail", 0, 14'h0100, 32'h00010203, 1'b0, 1'b0);
        else                   do_txn("cont tail", 1, 14'h0204, 32'h04050607, 1'b0, 1'b0);

        // Randomized traffic against a cycle-level model of the spec rules
        pend[0] = 1'b0; pend[1] = 1'b0;
        out_active = 1'b0; owner = 0; acc_n = 0;
        exp_d = '0; exp_e = 1'b0;
        lastg = last_grant_m;
        drop = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (drop == 0) req0_valid = 1'b0;
            if (drop == 1) req1_valid = 1'b0;
            drop = -1;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    paddr[p] = 14'($urandom_range(0, 16383));
                    if (p == 0) begin req0_valid = 1'b1; req0_addr = paddr[0]; end
                    else        begin req1_valid = 1'b1; req1_addr = paddr[1]; end
                end
            end
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            w = -1;
            if (!out_active && (pend[0] || pend[1]))
                w = (pend[0] && pend[1]) ? (RR ? 1 - lastg : 1) : (pend[1] ? 1 : 0);
            ev = out_active && (n >= acc_n + 2);
            chk("rnd ready0", req0_ready, w == 0);
            chk("rnd ready1", req1_ready, w == 1);
            chk("rnd rsp0_valid", rsp0_valid, ev && owner == 0);
            chk("rnd rsp1_valid", rsp1_valid, ev && owner == 1);
            chk("rnd busy", busy, out_active);
            if (w >= 0) chk("rnd rom_addr", rom_addr, paddr[w]);
            if (ev) begin
                chk("rnd data", (owner == 1) ? rsp1_data : rsp0_data, exp_d);
                chk("rnd err", (owner == 1) ? rsp1_err : rsp0_err, exp_e);
            end
            if (w >= 0) begin
                out_active = 1'b1;
                owner = w;
                acc_n = n;
                exp_d = romword(paddr[w]);
                exp_e = (paddr[w][1:0] != 2'b00);
                lastg = w;
                pend[w] = 1'b0;
                drop = w;
            end else if (ev && ((owner == 1) ? rsp1_ready : rsp0_ready)) begin
                out_active = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
